regfile_seq_ctrl: RTL and testbench

Command sequencer for the 8x8 general-purpose register file (R0..R7). It accepts one register-level command at a time over a valid/ready handshake. It translates each command into correctly timed enab/mux_sel/seg/OR2 drive, captures read data, and runs the read–ALU–writeback sequence with an ALU handshake and timeout. It sits between instruction decode and the register file and is the only block that drives the register file's control inputs.

---
 rtl/regfile_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl.sv
// Command sequencer for the 8x8 register file: turns one register-level command at a time
// into timed enab/mux/seg/or2 drive, captures read data and runs the read-ALU-writeback flow.
module regfile_seq_ctrl #(
  parameter int ALU_TIMEOUT  = 15,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_reg,
  input  logic [7:0] cmd_imm,
  output logic [1:0] rf_enab,
  output logic [1:0] rf_mux_sel,
  output logic [2:0] rf_seg,
  output logic [7:0] rf_or2,
  input  logic [7:0] rf_dout_a,
  input  logic [7:0] rf_dout_b,
  output logic       alu_start,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       cmd_done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_RST_CLR  = 3'd0,
    S_CLR_CYC  = 3'd1,
    S_IDLE     = 3'd2,
    S_EXEC     = 3'd3,
    S_RD_REQ   = 3'd4,
    S_ALU_RD   = 3'd5,
    S_ALU_WAIT = 3'd6,
    S_ALU_WB   = 3'd7
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_MOVN = 3'b010;
  localparam logic [2:0] OP_MOV0 = 3'b011;
  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_RD   = 3'b110;

  localparam logic [1:0] EN_CLR  = 2'b00;
  localparam logic [1:0] EN_WR   = 2'b01;
  localparam logic [1:0] EN_HOLD = 2'b10;
  localparam logic [1:0] EN_RD   = 2'b11;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] TO_LIMIT = 8'(ALU_TIMEOUT);

  state_t     r_state;
  logic [2:0] r_reg;
  logic [7:0] r_cnt;
  logic       r_cmd_ready;
  logic [1:0] r_rf_enab;
  logic [1:0] r_rf_mux_sel;
  logic [2:0] r_rf_seg;
  logic [7:0] r_rf_or2;
  logic       r_alu_start;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;
  logic       r_cmd_done;
  logic       r_err;
  logic [1:0] r_err_code;

  logic       w_accept;
  logic [7:0] w_cnt_next;
  logic       w_timeout;

  assign w_accept   = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
  assign w_cnt_next = r_cnt + 8'd1;
  assign w_timeout  = (w_cnt_next == TO_LIMIT);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= CLR_ON_RESET ? S_RST_CLR : S_IDLE;
      r_reg        <= 3'd0;
      r_cnt        <= 8'd0;
      r_cmd_ready  <= 1'b0;
      r_rf_enab    <= EN_HOLD;
      r_rf_mux_sel <= 2'b00;
      r_rf_seg     <= 3'd0;
      r_rf_or2     <= 8'h00;
      r_alu_start  <= 1'b0;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 8'h00;
      r_cmd_done   <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      // Pulses and enab fall back every cycle so clear/write never lasts beyond one cycle.
      r_rf_enab   <= EN_HOLD;
      r_alu_start <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_RST_CLR: begin
          r_rf_enab   <= EN_CLR;
          r_cmd_ready <= 1'b0;
          r_state     <= S_CLR_CYC;
        end
        S_CLR_CYC: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_reg <= cmd_reg;
            case (cmd_op)
              OP_NOP: begin
                r_cmd_ready <= 1'b0;
                r_state     <= S_EXEC;
              end
              OP_CLR: begin
                r_rf_enab   <= EN_CLR;
                r_cmd_ready <= 1'b0;
                r_state     <= S_EXEC;
              end
              OP_MOVN: begin
                r_rf_enab    <= EN_WR;
                r_rf_mux_sel <= 2'b00;
                r_rf_seg     <= cmd_reg;
                r_cmd_ready  <= 1'b0;
                r_state      <= S_EXEC;
              end
              OP_MOV0: begin
                r_rf_enab    <= EN_WR;
                r_rf_mux_sel <= 2'b01;
                r_rf_seg     <= cmd_reg;
                r_cmd_ready  <= 1'b0;
                r_state      <= S_EXEC;
              end
              OP_MVI: begin
                r_rf_enab    <= EN_WR;
                r_rf_mux_sel <= 2'b10;
                r_rf_seg     <= cmd_reg;
                r_rf_or2     <= cmd_imm;
                r_cmd_ready  <= 1'b0;
                r_state      <= S_EXEC;
              end
              OP_RD: begin
                r_rf_enab   <= EN_RD;
                r_rf_seg    <= cmd_reg;
                r_cmd_ready <= 1'b0;
                r_state     <= S_RD_REQ;
              end
              OP_ALU: begin
                r_rf_enab   <= EN_RD;
                r_rf_seg    <= cmd_reg;
                r_cnt       <= 8'd0;
                r_cmd_ready <= 1'b0;
                r_state     <= S_ALU_RD;
              end
              default: begin
                // Illegal op: report immediately and stay ready, no register-file activity.
                r_err      <= 1'b1;
                r_err_code <= ERR_ILLEGAL;
                r_state    <= S_IDLE;
              end
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          r_cmd_done  <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_RD_REQ: begin
          r_rd_data   <= rf_dout_b;
          r_rd_valid  <= 1'b1;
          r_cmd_done  <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_ALU_RD: begin
          r_alu_a     <= rf_dout_a;
          r_alu_b     <= rf_dout_b;
          r_alu_start <= 1'b1;
          r_cnt       <= 8'd0;
          r_state     <= S_ALU_WAIT;
        end
        S_ALU_WAIT: begin
          // A done sampled on the expiry cycle still wins over the timeout.
          if (alu_done) begin
            r_rf_enab    <= EN_WR;
            r_rf_mux_sel <= 2'b11;
            r_rf_seg     <= r_reg;
            r_cnt        <= 8'd0;
            r_state      <= S_ALU_WB;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
            r_cnt       <= 8'd0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt   <= w_cnt_next;
            r_state <= S_ALU_WAIT;
          end
        end
        S_ALU_WB: begin
          r_cmd_done  <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rf_enab    = r_rf_enab;
  assign rf_mux_sel = r_rf_mux_sel;
  assign rf_seg     = r_rf_seg;
  assign rf_or2     = r_rf_or2;
  assign alu_start  = r_alu_start;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign cmd_done   = r_cmd_done;
  assign err        = r_err;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl: table of single-command vectors plus hand-written
// ALU, timeout and mid-command reset sequences against a small register-file/ALU environment.
module tb_regfile_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_reg;
  logic [7:0] cmd_imm;
  logic [1:0] rf_enab;
  logic [1:0] rf_mux_sel;
  logic [2:0] rf_seg;
  logic [7:0] rf_or2;
  logic [7:0] rf_dout_a;
  logic [7:0] rf_dout_b;
  logic       alu_start;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_done;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       cmd_done;
  logic       err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_seq_ctrl #(.ALU_TIMEOUT(15), .CLR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_imm(cmd_imm),
    .rf_enab(rf_enab), .rf_mux_sel(rf_mux_sel), .rf_seg(rf_seg), .rf_or2(rf_or2),
    .rf_dout_a(rf_dout_a), .rf_dout_b(rf_dout_b),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .cmd_done(cmd_done), .err(err), .err_code(err_code)
  );

  // Register-file environment; the ALU result is simply a + b.
  logic [7:0] rf_mem [8];
  logic [7:0] alu_res;
  assign rf_dout_a = rf_mem[0];
  assign rf_dout_b = rf_mem[rf_seg];
  assign alu_res   = alu_a + alu_b;

  always @(posedge clk) begin
    case (rf_enab)
      2'b00: for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
      2'b01: begin
        case (rf_mux_sel)
          2'b00:   rf_mem[rf_seg] <= rf_mem[0];
          2'b01:   rf_mem[0]      <= rf_mem[rf_seg];
          2'b10:   rf_mem[rf_seg] <= rf_or2;
          default: rf_mem[rf_seg] <= alu_res;
        endcase
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rg;
    logic [7:0] imm;
    logic [1:0] enab;
    logic [1:0] mux;
    logic       chk_mux;
    logic       chk_seg;
    logic       chk_or2;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rg, input logic [7:0] imm);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_reg   = rg;
    cmd_imm   = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.op, v.rg, v.imm);
    if (v.op == 3'b111) begin
      chk("ill_err", err, 1);
      chk("ill_code", err_code, 2'b01);
      chk("ill_enab", rf_enab, 2'b10);
      chk("ill_done", cmd_done, 0);
      chk("ill_ready", cmd_ready, 1);
    end else begin
      chk("exec_enab", rf_enab, v.enab);
      chk("exec_ready", cmd_ready, 0);
      if (v.chk_mux) chk("exec_mux", rf_mux_sel, v.mux);
      if (v.chk_seg) chk("exec_seg", rf_seg, v.rg);
      if (v.chk_or2) chk("exec_or2", rf_or2, v.imm);
      @(negedge clk);
      chk("done_pulse", cmd_done, 1);
      chk("done_err", err, 0);
      chk("done_ready", cmd_ready, 1);
      chk("done_enab", rf_enab, 2'b10);
      if (v.op == 3'b110) begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, v.rd);
      end else begin
        chk("no_rd_valid", rd_valid, 0);
      end
    end
  endtask

  // d = wait cycle in which alu_done is driven high (0 = never).
  task automatic alu_run(input logic [2:0] rg, input int d, input logic [7:0] ea, input logic [7:0] eb);
    int starts = 0;
    int start_idx = -1;
    int wbs = 0;
    int wb_idx = -1;
    int done_idx = -1;
    int err_idx = -1;
    issue(3'b101, rg, 8'h00);
    chk("alurd_enab", rf_enab, 2'b11);
    chk("alurd_seg", rf_seg, rg);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
      end
      if (alu_start) begin
        starts++;
        if (start_idx < 0) start_idx = i;
      end
      if (rf_enab == 2'b01) begin
        wbs++;
        wb_idx = i;
        chk("wb_mux", rf_mux_sel, 2'b11);
        chk("wb_seg", rf_seg, rg);
      end
      if (cmd_done && done_idx < 0) done_idx = i;
      if (err && err_idx < 0) begin
        err_idx = i;
        chk("to_code", err_code, 2'b10);
      end
      alu_done = (i + 1 == d);
    end
    alu_done = 1'b0;
    chk("alu_start_cnt", starts, 1);
    chk("alu_start_idx", start_idx, 0);
    if (d > 0) begin
      chk("wb_cnt", wbs, 1);
      chk("wb_idx", wb_idx, d);
      chk("wb_done_idx", done_idx, d + 1);
      chk("wb_no_err", err_idx, -1);
    end else begin
      chk("to_no_wb", wbs, 0);
      chk("to_err_idx", err_idx, 15);
      chk("to_no_done", done_idx, -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_reg = 3'd0; cmd_imm = 8'h00; alu_done = 1'b0;

    //          op      rg    imm    enab   mux   cm    cs    co    rd
    vecs[0]  = '{3'b100, 3'd3, 8'hA5, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[1]  = '{3'b110, 3'd3, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2]  = '{3'b100, 3'd0, 8'h3C, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[3]  = '{3'b010, 3'd5, 8'h00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{3'b100, 3'd0, 8'h11, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[5]  = '{3'b011, 3'd5, 8'h00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{3'b110, 3'd0, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[7]  = '{3'b110, 3'd5, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[8]  = '{3'b000, 3'd1, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{3'b111, 3'd2, 8'h00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{3'b001, 3'd0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{3'b110, 3'd3, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[12] = '{3'b100, 3'd0, 8'h10, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[13] = '{3'b100, 3'd2, 8'h22, 2'b01, 2'b10, 1'b1, 1'b1, 1'b1, 8'h00};

    // Power-on reset and the single clear cycle that follows release.
    repeat (3) @(negedge clk);
    chk("rst_enab", rf_enab, 2'b10);
    chk("rst_mux", rf_mux_sel, 2'b00);
    chk("rst_seg", rf_seg, 3'd0);
    chk("rst_or2", rf_or2, 8'h00);
    chk("rst_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_done", cmd_done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 2'b00);
    chk("rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_enab", rf_enab, 2'b00);
    chk("clr_ready", cmd_ready, 0);
    chk("clr_done", cmd_done, 0);
    @(negedge clk);
    chk("post_clr_enab", rf_enab, 2'b10);
    chk("post_clr_ready", cmd_ready, 1);

    for (int k = 0; k < 14; k++) run_vec(vecs[k]);

    // ALU with done in the 4th wait cycle: R2 = 0x10 + 0x22.
    alu_run(3'd2, 4, 8'h10, 8'h22);
    v = '{3'b110, 3'd2, 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 8'h32};
    run_vec(v);

    // Done coincident with timeout expiry still writes back: R2 = 0x10 + 0x32.
    alu_run(3'd2, 15, 8'h10, 8'h32);
    v.rd = 8'h42;
    run_vec(v);

    // No done at all: timeout error, R2 untouched, error code held afterwards.
    alu_run(3'd2, 0, 8'h10, 8'h42);
    run_vec(v);
    chk("code_held", err_code, 2'b10);

    // Reset in the middle of ALU_WAIT: no writeback, no pulses, clear then idle.
    issue(3'b101, 3'd2, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_enab", rf_enab, 2'b10);
    chk("mid_rst_done", cmd_done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_code", err_code, 2'b00);
    chk("mid_rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_clr_enab", rf_enab, 2'b00);
    chk("mid_clr_done", cmd_done, 0);
    @(negedge clk);
    chk("mid_idle_enab", rf_enab, 2'b10);
    chk("mid_idle_ready", cmd_ready, 1);
    v.rd = 8'h00;
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
